// File: rtl/go_pkg.sv
// Shared types for the Go turn sequencer: cell encoding, packed board, move request and FSM states.
// Helper functions decode a board cell and bump the saturating move counter.
package go_pkg;

  localparam int BOARD_N = 9;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BLACK = 2'b01,
    WHITE = 2'b10
  } cell_t;

  // Bit plane first: a cell is {plane[1], plane[0]} at [row][col].
  typedef logic [1:0][BOARD_N-1:0][BOARD_N-1:0] board_t;

  typedef struct packed {
    logic       pass;
    logic [3:0] row;
    logic [3:0] col;
  } move_t;

  typedef enum logic [2:0] {
    S_WAIT_MOVE = 3'd0,
    S_CHECK     = 3'd1,
    S_START     = 3'd2,
    S_WAIT_UPD  = 3'd3,
    S_COMMIT    = 3'd4,
    S_OVER      = 3'd5
  } state_t;

  function automatic cell_t cell_at(input board_t b, input logic [3:0] r, input logic [3:0] c);
    return cell_t'({b[1][r][c], b[0][r][c]});
  endfunction

  function automatic logic [8:0] sat_inc9(input logic [8:0] v);
    return (v == 9'd511) ? v : v + 9'd1;
  endfunction

endpackage

// File: rtl/turn_timer.sv
// Per-turn countdown: reloads on load_in, counts down while enabled, pulses expire_out on the last cycle.
// Only instantiated when TURN_SEQ_MOVE_TIMER_EN is defined.
module turn_timer #(
  parameter int unsigned CYCLES = 1_950_000_000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        load_in,
  input  logic        enable_in,
  output logic        expire_out,
  output logic [31:0] remaining_out
);

  logic [31:0] remaining_q, remaining_d;

  // Reload wins over counting; the counter parks at zero until the next reload.
  always_comb begin
    remaining_d = remaining_q;
    if (load_in) begin
      remaining_d = 32'(CYCLES);
    end else if (enable_in && (remaining_q != 32'd0)) begin
      remaining_d = remaining_q - 32'd1;
    end else begin
      remaining_d = remaining_q;
    end
  end

  // Countdown register, starts full out of reset.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      remaining_q <= 32'(CYCLES);
    end else begin
      remaining_q <= remaining_d;
    end
  end

  assign expire_out    = enable_in && (remaining_q == 32'd1);
  assign remaining_out = remaining_q;

endmodule

// File: rtl/turn_sequencer.sv
// Game-level controller around board_updater: admits the side to move, screens moves, runs the
// updater handshake with a watchdog, commits boards and detects game end. Optional TURN_SEQ_MOVE_TIMER_EN.
module turn_sequencer
  import go_pkg::*;
#(
  parameter logic        LOCAL_COLOR = 1'b0,
  parameter int unsigned UPD_TIMEOUT = 64
`ifdef TURN_SEQ_MOVE_TIMER_EN
  ,
  parameter int unsigned TURN_CYCLES = 1_950_000_000
`endif
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       loc_valid_in,
  input  logic [8:0] loc_move_in,
  output logic       loc_ready_out,
  input  logic       rem_valid_in,
  input  logic [8:0] rem_move_in,
  output logic       rem_ready_out,
  input  logic       new_game_in,
  output logic       upd_start_out,
  output logic       upd_rst_out,
  output logic       upd_turn_out,
  output logic [7:0] upd_move_out,
  input  logic       upd_board_ready_in,
  input  board_t     upd_next_board_in,
  output board_t     board_out,
  output logic       turn_out,
  output logic       reject_out,
  output logic       game_over_out,
  output logic       err_timeout_out,
  output logic [8:0] move_count_out
`ifdef TURN_SEQ_MOVE_TIMER_EN
  ,
  output logic [31:0] timer_out
`endif
);

  localparam int UPD_CNT_W = $clog2(UPD_TIMEOUT + 1);

  state_t               state_q, state_d;
  board_t               board_q, board_d;
  move_t                move_q, move_d;
  logic                 turn_q, turn_d;
  logic [8:0]           move_count_q, move_count_d;
  logic [1:0]           pass_cnt_q, pass_cnt_d;
  logic                 game_over_q, game_over_d;
  logic                 err_timeout_q, err_timeout_d;
  logic                 reject_q, reject_d;
  logic                 upd_start_q, upd_start_d;
  logic                 upd_rst_q, upd_rst_d;
  logic                 new_game_pend_q, new_game_pend_d;
  logic [UPD_CNT_W-1:0] upd_cnt_q, upd_cnt_d;

  logic loc_owner_s, do_new_game_s, timer_expire_s, illegal_s;
  logic loc_ready_s, rem_ready_s;

  assign loc_owner_s   = (turn_q == LOCAL_COLOR);
  assign do_new_game_s = ((state_q == S_WAIT_MOVE) || (state_q == S_OVER)) &&
                         (new_game_in || new_game_pend_q);
  assign illegal_s     = (move_q.row > 4'd8) || (move_q.col > 4'd8) ||
                         (cell_at(board_q, move_q.row, move_q.col) != EMPTY);

`ifdef TURN_SEQ_MOVE_TIMER_EN
  logic timer_load_s, timer_en_s;

  assign timer_load_s = (turn_d != turn_q) || do_new_game_s;
  assign timer_en_s   = (state_q == S_WAIT_MOVE);

  turn_timer #(
    .CYCLES (TURN_CYCLES)
  ) u_turn_timer (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .load_in       (timer_load_s),
    .enable_in     (timer_en_s),
    .expire_out    (timer_expire_s),
    .remaining_out (timer_out)
  );
`else
  assign timer_expire_s = 1'b0;
`endif

  // Next-state, request acceptance and bookkeeping for the turn FSM.
  always_comb begin
    state_d         = state_q;
    board_d         = board_q;
    move_d          = move_q;
    turn_d          = turn_q;
    move_count_d    = move_count_q;
    pass_cnt_d      = pass_cnt_q;
    game_over_d     = game_over_q;
    err_timeout_d   = err_timeout_q;
    reject_d        = 1'b0;
    upd_start_d     = 1'b0;
    upd_rst_d       = 1'b0;
    upd_cnt_d       = upd_cnt_q;
    new_game_pend_d = new_game_pend_q;
    loc_ready_s     = 1'b0;
    rem_ready_s     = 1'b0;

    // A new game arriving mid-move waits until the in-flight move has settled.
    if (new_game_in && !((state_q == S_WAIT_MOVE) || (state_q == S_OVER))) begin
      new_game_pend_d = 1'b1;
    end else begin
      new_game_pend_d = new_game_pend_q;
    end

    case (state_q)
      S_WAIT_MOVE, S_OVER: begin
        if (do_new_game_s) begin
          state_d         = S_WAIT_MOVE;
          board_d         = '0;
          turn_d          = 1'b0;
          move_count_d    = 9'd0;
          pass_cnt_d      = 2'd0;
          game_over_d     = 1'b0;
          err_timeout_d   = 1'b0;
          new_game_pend_d = 1'b0;
        end else if (state_q == S_OVER) begin
          state_d = S_OVER;
        end else if (timer_expire_s) begin
          move_d  = '{pass: 1'b1, row: 4'd0, col: 4'd0};
          state_d = S_CHECK;
        end else if (loc_owner_s && loc_valid_in) begin
          loc_ready_s = 1'b1;
          move_d      = move_t'(loc_move_in);
          state_d     = S_CHECK;
        end else if (!loc_owner_s && rem_valid_in) begin
          rem_ready_s = 1'b1;
          move_d      = move_t'(rem_move_in);
          state_d     = S_CHECK;
        end else begin
          state_d = S_WAIT_MOVE;
        end
      end

      S_CHECK: begin
        if (move_q.pass) begin
          turn_d       = ~turn_q;
          move_count_d = sat_inc9(move_count_q);
          if (pass_cnt_q == 2'd1) begin
            pass_cnt_d  = 2'd2;
            game_over_d = 1'b1;
            state_d     = S_OVER;
          end else begin
            pass_cnt_d = pass_cnt_q + 2'd1;
            state_d    = S_WAIT_MOVE;
          end
        end else if (illegal_s) begin
          reject_d = 1'b1;
          state_d  = S_WAIT_MOVE;
        end else begin
          pass_cnt_d  = 2'd0;
          upd_start_d = 1'b1;
          state_d     = S_START;
        end
      end

      S_START: begin
        upd_cnt_d = '0;
        state_d   = S_WAIT_UPD;
      end

      // The updater gets UPD_TIMEOUT full cycles here before it is reset and the move dropped.
      S_WAIT_UPD: begin
        if (upd_board_ready_in) begin
          state_d = S_COMMIT;
        end else if (upd_cnt_q == UPD_CNT_W'(UPD_TIMEOUT - 1)) begin
          upd_rst_d     = 1'b1;
          err_timeout_d = 1'b1;
          state_d       = S_WAIT_MOVE;
        end else begin
          upd_cnt_d = upd_cnt_q + UPD_CNT_W'(1);
        end
      end

      S_COMMIT: begin
        board_d      = upd_next_board_in;
        turn_d       = ~turn_q;
        move_count_d = sat_inc9(move_count_q);
        state_d      = S_WAIT_MOVE;
      end

      default: begin
        state_d = S_WAIT_MOVE;
      end
    endcase
  end

  // Sequencer registers; upd_rst_q leaves reset asserted so the updater sees one clean reset edge.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q         <= S_WAIT_MOVE;
      board_q         <= '0;
      move_q          <= '0;
      turn_q          <= 1'b0;
      move_count_q    <= 9'd0;
      pass_cnt_q      <= 2'd0;
      game_over_q     <= 1'b0;
      err_timeout_q   <= 1'b0;
      reject_q        <= 1'b0;
      upd_start_q     <= 1'b0;
      upd_rst_q       <= 1'b1;
      new_game_pend_q <= 1'b0;
      upd_cnt_q       <= '0;
    end else begin
      state_q         <= state_d;
      board_q         <= board_d;
      move_q          <= move_d;
      turn_q          <= turn_d;
      move_count_q    <= move_count_d;
      pass_cnt_q      <= pass_cnt_d;
      game_over_q     <= game_over_d;
      err_timeout_q   <= err_timeout_d;
      reject_q        <= reject_d;
      upd_start_q     <= upd_start_d;
      upd_rst_q       <= upd_rst_d;
      new_game_pend_q <= new_game_pend_d;
      upd_cnt_q       <= upd_cnt_d;
    end
  end

  assign loc_ready_out   = loc_ready_s;
  assign rem_ready_out   = rem_ready_s;
  assign upd_start_out   = upd_start_q;
  assign upd_rst_out     = upd_rst_q;
  assign upd_turn_out    = turn_q;
  assign upd_move_out    = {move_q.row, move_q.col};
  assign board_out       = board_q;
  assign turn_out        = turn_q;
  assign reject_out      = reject_q;
  assign game_over_out   = game_over_q;
  assign err_timeout_out = err_timeout_q;
  assign move_count_out  = move_count_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// Directed self-checking bench for turn_sequencer (local = black, UPD_TIMEOUT = 64); the updater is
// emulated inline. Inputs change just after a falling edge, outputs are checked before the next rise.
module tb_turn_sequencer;
  import go_pkg::*;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       loc_valid_in, rem_valid_in, new_game_in, upd_board_ready_in;
  logic [8:0] loc_move_in, rem_move_in;
  logic       loc_ready_out, rem_ready_out, upd_start_out, upd_rst_out, upd_turn_out;
  logic [7:0] upd_move_out;
  board_t     upd_next_board_in, board_out, exp_board;
  logic       turn_out, reject_out, game_over_out, err_timeout_out;
  logic [8:0] move_count_out;
`ifdef TURN_SEQ_MOVE_TIMER_EN
  logic [31:0] timer_out;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  turn_sequencer #(
    .LOCAL_COLOR (1'b0),
    .UPD_TIMEOUT (64)
`ifdef TURN_SEQ_MOVE_TIMER_EN
    ,
    .TURN_CYCLES (100)
`endif
  ) dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .loc_valid_in       (loc_valid_in),
    .loc_move_in        (loc_move_in),
    .loc_ready_out      (loc_ready_out),
    .rem_valid_in       (rem_valid_in),
    .rem_move_in        (rem_move_in),
    .rem_ready_out      (rem_ready_out),
    .new_game_in        (new_game_in),
    .upd_start_out      (upd_start_out),
    .upd_rst_out        (upd_rst_out),
    .upd_turn_out       (upd_turn_out),
    .upd_move_out       (upd_move_out),
    .upd_board_ready_in (upd_board_ready_in),
    .upd_next_board_in  (upd_next_board_in),
    .board_out          (board_out),
    .turn_out           (turn_out),
    .reject_out         (reject_out),
    .game_over_out      (game_over_out),
    .err_timeout_out    (err_timeout_out),
    .move_count_out     (move_count_out)
`ifdef TURN_SEQ_MOVE_TIMER_EN
    ,
    .timer_out          (timer_out)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [1:0] tb_cell(input board_t b, input int r, input int c);
    return {b[1][r][c], b[0][r][c]};
  endfunction

  task automatic set_cell(input int r, input int c, input logic [1:0] v);
    exp_board[0][r][c] = v[0];
    exp_board[1][r][c] = v[1];
  endtask

  // One legal move by the owning port, answered by the emulated updater 6 cycles after start.
  task automatic play(input logic use_loc, input logic [3:0] r, input logic [3:0] c, input logic [1:0] colour);
    int n;
    if (use_loc) begin
      loc_valid_in = 1'b1;
      loc_move_in  = {1'b0, r, c};
    end else begin
      rem_valid_in = 1'b1;
      rem_move_in  = {1'b0, r, c};
    end
    #1;
    check("play_accept", 32'(use_loc ? loc_ready_out : rem_ready_out), 32'd1);
    set_cell(int'(r), int'(c), colour);
    upd_next_board_in = exp_board;
    @(negedge clk_in);
    loc_valid_in = 1'b0;
    rem_valid_in = 1'b0;
    n = 0;
    while (!upd_start_out && n < 8) begin
      @(negedge clk_in);
      n++;
    end
    check("play_start_seen", 32'(upd_start_out), 32'd1);
    repeat (6) @(negedge clk_in);
    upd_board_ready_in = 1'b1;
    @(negedge clk_in);
    upd_board_ready_in = 1'b0;
    @(negedge clk_in);
    check("play_board", 32'(board_out == exp_board), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [8:0] bad_moves [2];
    rst_in             = 1'b0;
    loc_valid_in       = 1'b0;
    rem_valid_in       = 1'b0;
    new_game_in        = 1'b0;
    upd_board_ready_in = 1'b0;
    loc_move_in        = 9'd0;
    rem_move_in        = 9'd0;
    upd_next_board_in  = '0;
    exp_board          = '0;

    // Reset state and upd_rst release
    repeat (2) @(negedge clk_in);
    check("rst_board", 32'(board_out == exp_board), 32'd1);
    check("rst_turn", 32'(turn_out), 32'd0);
    check("rst_upd_rst", 32'(upd_rst_out), 32'd1);
    check("rst_count", 32'(move_count_out), 32'd0);
    check("rst_flags", 32'({game_over_out, err_timeout_out, reject_out, upd_start_out}), 32'd0);
    rst_in = 1'b1;
    #1;
    check("upd_rst_after_release", 32'(upd_rst_out), 32'd1);
    @(negedge clk_in);
    check("upd_rst_deasserted", 32'(upd_rst_out), 32'd0);

    // Black (local) plays (4,4): ready same cycle, start 2 cycles later, board 9 edges after accept
    loc_valid_in = 1'b1;
    loc_move_in  = {1'b0, 4'd4, 4'd4};
    #1;
    check("m1_loc_ready", 32'(loc_ready_out), 32'd1);
    check("m1_rem_ready", 32'(rem_ready_out), 32'd0);
    set_cell(4, 4, 2'b01);
    upd_next_board_in = exp_board;
    @(negedge clk_in);
    #1;
    check("m1_ready_pulse", 32'(loc_ready_out), 32'd0);
    check("m1_no_early_start", 32'(upd_start_out), 32'd0);
    loc_valid_in = 1'b0;
    @(negedge clk_in);
    check("m1_start", 32'(upd_start_out), 32'd1);
    check("m1_upd_move", 32'(upd_move_out), 32'h44);
    check("m1_upd_turn", 32'(upd_turn_out), 32'd0);
    @(negedge clk_in);
    check("m1_start_one_cycle", 32'(upd_start_out), 32'd0);
    repeat (5) @(negedge clk_in);
    upd_board_ready_in = 1'b1;
    @(negedge clk_in);
    upd_board_ready_in = 1'b0;
    check("m1_not_committed_yet", 32'(tb_cell(board_out, 4, 4)), 32'd0);
    @(negedge clk_in);
    check("m1_cell44_black", 32'(tb_cell(board_out, 4, 4)), 32'd1);
    check("m1_board", 32'(board_out == exp_board), 32'd1);
    check("m1_turn", 32'(turn_out), 32'd1);
    check("m1_count", 32'(move_count_out), 32'd1);

    // White's turn: both valid, only remote admitted; local stays unaccepted
    loc_valid_in = 1'b1;
    loc_move_in  = {1'b0, 4'd1, 4'd1};
    rem_valid_in = 1'b1;
    rem_move_in  = {1'b0, 4'd0, 4'd0};
    #1;
    check("m2_rem_ready", 32'(rem_ready_out), 32'd1);
    check("m2_loc_ignored", 32'(loc_ready_out), 32'd0);
    set_cell(0, 0, 2'b10);
    upd_next_board_in = exp_board;
    @(negedge clk_in);
    rem_valid_in = 1'b0;
    #1;
    check("m2_loc_held_check", 32'(loc_ready_out), 32'd0);
    repeat (7) @(negedge clk_in);
    check("m2_loc_held_wait", 32'(loc_ready_out), 32'd0);
    upd_board_ready_in = 1'b1;
    @(negedge clk_in);
    upd_board_ready_in = 1'b0;
    loc_valid_in       = 1'b0;
    @(negedge clk_in);
    check("m2_cell00_white", 32'(tb_cell(board_out, 0, 0)), 32'd2);
    check("m2_board", 32'(board_out == exp_board), 32'd1);
    check("m2_turn", 32'(turn_out), 32'd0);
    check("m2_count", 32'(move_count_out), 32'd2);

    // Occupied cell, then row 9: each rejected, no updater start, turn unchanged
    bad_moves[0] = {1'b0, 4'd4, 4'd4};
    bad_moves[1] = {1'b0, 4'd9, 4'd2};
    for (int i = 0; i < 2; i++) begin
      loc_valid_in = 1'b1;
      loc_move_in  = bad_moves[i];
      #1;
      check("rej_accept", 32'(loc_ready_out), 32'd1);
      @(negedge clk_in);
      loc_valid_in = 1'b0;
      @(negedge clk_in);
      check("rej_pulse", 32'(reject_out), 32'd1);
      check("rej_no_start", 32'(upd_start_out), 32'd0);
      check("rej_turn", 32'(turn_out), 32'd0);
      @(negedge clk_in);
      check("rej_pulse_end", 32'(reject_out), 32'd0);
    end
    check("rej_count", 32'(move_count_out), 32'd2);
    check("rej_board", 32'(board_out == exp_board), 32'd1);

    // Updater never answers: WAIT_UPD holds 64 full cycles, then upd_rst pulses and error sticks
    loc_valid_in = 1'b1;
    loc_move_in  = {1'b0, 4'd2, 4'd2};
    #1;
    check("to_accept", 32'(loc_ready_out), 32'd1);
    @(negedge clk_in);
    loc_valid_in = 1'b0;
    @(negedge clk_in);
    check("to_start", 32'(upd_start_out), 32'd1);
    repeat (64) @(negedge clk_in);
    check("to_not_yet", 32'(upd_rst_out), 32'd0);
    @(negedge clk_in);
    check("to_upd_rst", 32'(upd_rst_out), 32'd1);
    check("to_err", 32'(err_timeout_out), 32'd1);
    check("to_turn", 32'(turn_out), 32'd0);
    check("to_board", 32'(board_out == exp_board), 32'd1);
    check("to_count", 32'(move_count_out), 32'd2);
    @(negedge clk_in);
    check("to_upd_rst_end", 32'(upd_rst_out), 32'd0);
    check("to_err_sticky", 32'(err_timeout_out), 32'd1);

    // New game with a simultaneous valid: new game wins
    new_game_in  = 1'b1;
    loc_valid_in = 1'b1;
    loc_move_in  = {1'b0, 4'd5, 4'd5};
    #1;
    check("ng_no_ready", 32'(loc_ready_out), 32'd0);
    @(negedge clk_in);
    new_game_in  = 1'b0;
    loc_valid_in = 1'b0;
    exp_board    = '0;
    check("ng_board", 32'(board_out == exp_board), 32'd1);
    check("ng_err", 32'(err_timeout_out), 32'd0);
    check("ng_count", 32'(move_count_out), 32'd0);

    // Two passes end the game
    loc_valid_in = 1'b1;
    loc_move_in  = {1'b1, 4'd0, 4'd0};
    #1;
    check("p1_ready", 32'(loc_ready_out), 32'd1);
    @(negedge clk_in);
    loc_valid_in = 1'b0;
    @(negedge clk_in);
    check("p1_turn", 32'(turn_out), 32'd1);
    check("p1_count", 32'(move_count_out), 32'd1);
    check("p1_no_start", 32'(upd_start_out), 32'd0);
    rem_valid_in = 1'b1;
    rem_move_in  = {1'b1, 4'd0, 4'd0};
    #1;
    check("p2_ready", 32'(rem_ready_out), 32'd1);
    @(negedge clk_in);
    rem_valid_in = 1'b0;
    @(negedge clk_in);
    check("p2_game_over", 32'(game_over_out), 32'd1);
    check("p2_count", 32'(move_count_out), 32'd2);
    check("p2_turn", 32'(turn_out), 32'd0);
    loc_valid_in = 1'b1;
    loc_move_in  = {1'b0, 4'd3, 4'd3};
    #1;
    check("over_loc_ignored", 32'(loc_ready_out), 32'd0);
    repeat (3) @(negedge clk_in);
    check("over_still_ignored", 32'({loc_ready_out, upd_start_out}), 32'd0);
    check("over_sticky", 32'(game_over_out), 32'd1);
    loc_valid_in = 1'b0;
    new_game_in  = 1'b1;
    @(negedge clk_in);
    new_game_in = 1'b0;
    check("over_ng_flag", 32'(game_over_out), 32'd0);
    check("over_ng_count", 32'(move_count_out), 32'd0);
    check("over_ng_turn", 32'(turn_out), 32'd0);

    // New game during WAIT_UPD: the move still commits, then the board clears
    loc_valid_in = 1'b1;
    loc_move_in  = {1'b0, 4'd4, 4'd4};
    #1;
    check("lat_accept", 32'(loc_ready_out), 32'd1);
    set_cell(4, 4, 2'b01);
    upd_next_board_in = exp_board;
    @(negedge clk_in);
    loc_valid_in = 1'b0;
    repeat (2) @(negedge clk_in);
    new_game_in = 1'b1;
    @(negedge clk_in);
    new_game_in = 1'b0;
    repeat (4) @(negedge clk_in);
    upd_board_ready_in = 1'b1;
    @(negedge clk_in);
    upd_board_ready_in = 1'b0;
    @(negedge clk_in);
    check("lat_committed", 32'(board_out == exp_board), 32'd1);
    check("lat_turn", 32'(turn_out), 32'd1);
    @(negedge clk_in);
    exp_board = '0;
    check("lat_cleared", 32'(board_out == exp_board), 32'd1);
    check("lat_turn0", 32'(turn_out), 32'd0);
    check("lat_count0", 32'(move_count_out), 32'd0);

    // Asynchronous reset while the updater is busy
    play(1'b1, 4'd4, 4'd4, 2'b01);
    rem_valid_in = 1'b1;
    rem_move_in  = {1'b0, 4'd3, 4'd3};
    #1;
    check("ar_accept", 32'(rem_ready_out), 32'd1);
    @(negedge clk_in);
    rem_valid_in = 1'b0;
    repeat (4) @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    exp_board = '0;
    check("ar_board", 32'(board_out == exp_board), 32'd1);
    check("ar_turn", 32'(turn_out), 32'd0);
    check("ar_upd_rst", 32'(upd_rst_out), 32'd1);
    check("ar_count", 32'(move_count_out), 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    check("ar_upd_rst_end", 32'(upd_rst_out), 32'd0);

`ifdef TURN_SEQ_MOVE_TIMER_EN
    // Idle owner: pass injected after 100 WAIT_MOVE cycles, timer reloads on the turn change
    check("tm_running", timer_out, 32'd99);
    repeat (99) @(negedge clk_in);
    check("tm_not_yet", 32'(turn_out), 32'd0);
    @(negedge clk_in);
    check("tm_turn", 32'(turn_out), 32'd1);
    check("tm_count", 32'(move_count_out), 32'd1);
    check("tm_reload", timer_out, 32'd100);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
